// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and enables, and owns the NZCV flags and condition check.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  ALUControl,
   output logic [3:0]  Flags,
   output logic [3:0]  State
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;

   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic res;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [3:0] state_r, next_state_s;
   logic [3:0] flags_r, flags_nx_s;
   logic [3:0] cond_s, cmd_s, rd_s, alu_dec_s;
   logic [1:0] op_s;
   logic       i_bit_s, s_bit_s, l_bit_s, condex_s;
   logic       nowrite_s, is_cmp_s, logical_s, supported_s, flag_wr_s;
   logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s;
   logic       unused_s;

   assign cond_s   = Instr[31:28];
   assign op_s     = Instr[27:26];
   assign i_bit_s  = Instr[25];
   assign cmd_s    = Instr[24:21];
   assign s_bit_s  = Instr[20];
   assign l_bit_s  = Instr[20];
   assign rd_s     = Instr[15:12];
   assign unused_s = ^{Instr[19:16], Instr[11:0]};

   assign condex_s = cond_holds(cond_s, flags_r);
   assign ImmSrc   = op_s;
   assign RegSrc   = {(op_s == 2'b01), (op_s == 2'b10)};
   assign Flags    = flags_r;
   assign State    = state_r;

   // Data-processing command decode: ALU operation, write suppression, flag class
   always_comb begin
      alu_dec_s   = 4'b0000;
      nowrite_s   = 1'b1;
      is_cmp_s    = 1'b0;
      logical_s   = 1'b0;
      supported_s = 1'b1;
      case (cmd_s)
         4'b0100: begin alu_dec_s = 4'b0000; nowrite_s = 1'b0; end
         4'b0010: begin alu_dec_s = 4'b0001; nowrite_s = 1'b0; end
         4'b0000: begin alu_dec_s = 4'b0010; nowrite_s = 1'b0; logical_s = 1'b1; end
         4'b1100: begin alu_dec_s = 4'b0011; nowrite_s = 1'b0; logical_s = 1'b1; end
         4'b0001: begin alu_dec_s = 4'b0100; nowrite_s = 1'b0; logical_s = 1'b1; end
         4'b1010: begin alu_dec_s = 4'b0001; is_cmp_s  = 1'b1; end
         default: supported_s = 1'b0;
      endcase
   end

   // Logical ops keep the stored carry and overflow
   assign flag_wr_s  = ((state_r == S_EXECR) | (state_r == S_EXECI)) &
                       (s_bit_s | is_cmp_s) & condex_s & supported_s;
   assign flags_nx_s = {ALUFlags[3:2], logical_s ? flags_r[1:0] : ALUFlags[1:0]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= S_FETCH;
      else       state_r <= next_state_s;
   end

   // Flag register, captured at the end of an execute state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          flags_r <= 4'b0000;
      else if (flag_wr_s) flags_r <= flags_nx_s;
      else                flags_r <= flags_r;
   end

   // Next-state logic
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH:  next_state_s = S_DECODE;
         S_DECODE: begin
            case (op_s)
               2'b00:   next_state_s = i_bit_s ? S_EXECI : S_EXECR;
               2'b01:   next_state_s = S_MEMADR;
               2'b10:   next_state_s = S_BRANCH;
               default: next_state_s = S_FETCH;
            endcase
         end
         S_MEMADR: next_state_s = l_bit_s ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state_s = S_MEMWB;
         S_EXECR:  next_state_s = S_ALUWB;
         S_EXECI:  next_state_s = S_ALUWB;
         default:  next_state_s = S_FETCH;
      endcase
   end

   // Per-state datapath controls; unused encodings leave every enable low
   always_comb begin
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ResultSrc   = 2'b00;
      ALUControl  = 4'b0000;
      case (state_r)
         S_FETCH: begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc   = 2'b01;
            reg_write_s = condex_s;
         end
         S_MEMWR: begin
            AdrSrc      = 1'b1;
            mem_write_s = condex_s;
         end
         S_EXECR: ALUControl = alu_dec_s;
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec_s;
         end
         S_ALUWB:  reg_write_s = condex_s & ~nowrite_s & (rd_s != 4'd15);
         S_BRANCH: begin
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            pc_write_s = condex_s;
         end
         default: ALUControl = 4'b0000;
      endcase
   end

   assign PCWrite  = pc_write_s  & ~reset;
   assign IRWrite  = ir_write_s  & ~reset;
   assign MemWrite = mem_write_s & ~reset;
   assign RegWrite = reg_write_s & ~reset;

endmodule
